// File: rtl/lcd_pkg.sv
//==============================================================================
// Module : lcd_pkg
// Brief  : Opcodes and decoder state encoding for the LCD SPI receiver.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package lcd_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPIN   = 8'h10;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_INVOFF  = 8'h20;
  localparam logic [7:0] CMD_INVON   = 8'h21;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PARAM  = 2'd1,
    ST_RAM_HI = 2'd2,
    ST_RAM_LO = 2'd3
  } dec_state_t;

  function automatic logic is_window_cmd(input logic [7:0] op);
    return (op == CMD_CASET) || (op == CMD_RASET);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_spi_rx_shift.sv
//==============================================================================
// Module : lcd_spi_rx_shift
// Brief  : Input synchronisers, sclk edge detect and MSB-first byte shifter.
//          LCD_RX_STATS_EN adds the partial-byte drop pulse.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module lcd_spi_rx_shift #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_dc,
  input  logic       spi_mosi,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
`ifdef LCD_RX_STATS_EN
  ,
  output logic       partial_drop
`endif
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_dc_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_done;
  logic                   r_dc_lat;
  logic                   r_byte_valid;
  logic [7:0]             r_byte_data;
  logic                   r_byte_dc;

  logic w_sclk;
  logic w_cs_n;
  logic w_dc;
  logic w_mosi;
  logic w_rise;

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
  assign w_dc   = r_dc_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise = w_sclk & ~r_sclk_prev;

  // cs_n synchroniser resets high so the link starts deselected
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_dc_sync   <= '0;
      r_mosi_sync <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   spi_cs_n};
      r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0],   spi_dc};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sclk_prev <= 1'b0;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'd0;
      r_done      <= 1'b0;
      r_dc_lat    <= 1'b0;
    end else begin
      r_sclk_prev <= w_sclk;
      r_done      <= 1'b0;
      if (w_cs_n) begin
        r_bit_cnt <= 3'd0;
      end else if (w_rise) begin
        r_shift   <= {r_shift[6:0], w_mosi};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_done   <= 1'b1;
          r_dc_lat <= w_dc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_byte_valid <= 1'b0;
      r_byte_data  <= 8'd0;
      r_byte_dc    <= 1'b0;
    end else begin
      r_byte_valid <= r_done;
      if (r_done) begin
        r_byte_data <= r_shift;
        r_byte_dc   <= r_dc_lat;
      end
    end
  end

  assign byte_valid = r_byte_valid;
  assign byte_data  = r_byte_data;
  assign byte_dc    = r_byte_dc;

`ifdef LCD_RX_STATS_EN
  logic r_partial_drop;

  // fires once per deselect: the counter is already cleared on the next cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_partial_drop <= 1'b0;
    end else begin
      r_partial_drop <= w_cs_n && (r_bit_cnt != 3'd0);
    end
  end

  assign partial_drop = r_partial_drop;
`endif

endmodule

`default_nettype wire

// File: rtl/lcd_spi_rx.sv
//==============================================================================
// Module : lcd_spi_rx
// Brief  : LCD SPI receiver: command decoder, window registers and pixel
//          cursor. LCD_RX_STATS_EN adds err_count / pix_count.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module lcd_spi_rx
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COLS        = 128,
  parameter int ROWS        = 160
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_dc,
  input  logic        spi_mosi,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_dc,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [7:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic        frame_done,
  output logic        sleep_out,
  output logic        disp_on,
  output logic        invert_on,
  output logic [7:0]  madctl,
  output logic [7:0]  colmod
`ifdef LCD_RX_STATS_EN
  ,
  output logic [15:0] err_count,
  output logic [31:0] pix_count
`endif
);

  localparam logic [7:0] XE_RST = 8'(COLS - 1);
  localparam logic [7:0] YE_RST = 8'(ROWS - 1);

  logic       w_byte_valid;
  logic [7:0] w_byte_data;
  logic       w_byte_dc;
  logic       w_cmd;
  logic       w_data;

  dec_state_t r_state;
  dec_state_t w_state_nx;

  logic [7:0]  r_cmd;
  logic [2:0]  r_pidx;
  logic [7:0]  r_start_tmp;
  logic [7:0]  r_xs, r_xe, r_ys, r_ye;
  logic [7:0]  r_cx, r_cy;
  logic [7:0]  r_hi;
  logic        r_cmd_valid;
  logic [7:0]  r_cmd_code;
  logic        r_pix_valid;
  logic [15:0] r_pix_data;
  logic [7:0]  r_pix_x, r_pix_y;
  logic        r_frame_done;
  logic        r_sleep, r_disp, r_inv;
  logic [7:0]  r_madctl, r_colmod;

`ifdef LCD_RX_STATS_EN
  logic w_partial_drop;
`endif

  lcd_spi_rx_shift #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_shift (
    .clk          (clk),
    .resetn       (resetn),
    .spi_sclk     (spi_sclk),
    .spi_cs_n     (spi_cs_n),
    .spi_dc       (spi_dc),
    .spi_mosi     (spi_mosi),
    .byte_valid   (w_byte_valid),
    .byte_data    (w_byte_data),
    .byte_dc      (w_byte_dc)
`ifdef LCD_RX_STATS_EN
    ,
    .partial_drop (w_partial_drop)
`endif
  );

  assign w_cmd  = w_byte_valid & ~w_byte_dc;
  assign w_data = w_byte_valid &  w_byte_dc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (w_cmd) begin
      case (w_byte_data)
        CMD_SWRESET, CMD_SLPIN, CMD_SLPOUT, CMD_INVOFF,
        CMD_INVON, CMD_DISPOFF, CMD_DISPON: w_state_nx = ST_IDLE;
        CMD_RAMWR:                          w_state_nx = ST_RAM_HI;
        default:                            w_state_nx = ST_PARAM;
      endcase
    end else if (w_data) begin
      case (r_state)
        ST_RAM_HI: w_state_nx = ST_RAM_LO;
        ST_RAM_LO: w_state_nx = ST_RAM_HI;
        default:   w_state_nx = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cmd        <= 8'd0;
      r_pidx       <= 3'd0;
      r_start_tmp  <= 8'd0;
      r_xs         <= 8'd0;
      r_xe         <= XE_RST;
      r_ys         <= 8'd0;
      r_ye         <= YE_RST;
      r_cx         <= 8'd0;
      r_cy         <= 8'd0;
      r_hi         <= 8'd0;
      r_cmd_valid  <= 1'b0;
      r_cmd_code   <= 8'd0;
      r_pix_valid  <= 1'b0;
      r_pix_data   <= 16'd0;
      r_pix_x      <= 8'd0;
      r_pix_y      <= 8'd0;
      r_frame_done <= 1'b0;
      r_sleep      <= 1'b0;
      r_disp       <= 1'b0;
      r_inv        <= 1'b0;
      r_madctl     <= 8'd0;
      r_colmod     <= 8'd0;
    end else begin
      r_cmd_valid  <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_cmd) begin
        r_cmd_valid <= 1'b1;
        r_cmd_code  <= w_byte_data;
        r_cmd       <= w_byte_data;
        r_pidx      <= 3'd0;
        case (w_byte_data)
          CMD_SWRESET: begin
            r_start_tmp <= 8'd0;
            r_xs        <= 8'd0;
            r_xe        <= XE_RST;
            r_ys        <= 8'd0;
            r_ye        <= YE_RST;
            r_cx        <= 8'd0;
            r_cy        <= 8'd0;
            r_hi        <= 8'd0;
            r_pix_data  <= 16'd0;
            r_pix_x     <= 8'd0;
            r_pix_y     <= 8'd0;
            r_sleep     <= 1'b0;
            r_disp      <= 1'b0;
            r_inv       <= 1'b0;
            r_madctl    <= 8'd0;
            r_colmod    <= 8'd0;
          end
          CMD_SLPIN:   r_sleep <= 1'b0;
          CMD_SLPOUT:  r_sleep <= 1'b1;
          CMD_INVOFF:  r_inv   <= 1'b0;
          CMD_INVON:   r_inv   <= 1'b1;
          CMD_DISPOFF: r_disp  <= 1'b0;
          CMD_DISPON:  r_disp  <= 1'b1;
          CMD_RAMWR: begin
            r_cx <= r_xs;
            r_cy <= r_ys;
          end
          default: ;
        endcase
      end else if (w_data) begin
        case (r_state)
          ST_PARAM: begin
            if (r_pidx != 3'd4) r_pidx <= r_pidx + 3'd1;
            // window high bytes are ignored; registers commit only on the 4th param
            if (is_window_cmd(r_cmd)) begin
              if (r_pidx == 3'd1) begin
                r_start_tmp <= w_byte_data;
              end else if (r_pidx == 3'd3) begin
                if (r_cmd == CMD_CASET) begin
                  r_xs <= r_start_tmp;
                  r_xe <= w_byte_data;
                end else begin
                  r_ys <= r_start_tmp;
                  r_ye <= w_byte_data;
                end
              end
            end else if (r_pidx == 3'd0) begin
              if (r_cmd == CMD_MADCTL) r_madctl <= w_byte_data;
              if (r_cmd == CMD_COLMOD) r_colmod <= w_byte_data;
            end
          end
          ST_RAM_HI: r_hi <= w_byte_data;
          ST_RAM_LO: begin
            r_pix_valid <= 1'b1;
            r_pix_data  <= {r_hi, w_byte_data};
            r_pix_x     <= r_cx;
            r_pix_y     <= r_cy;
            if (r_cx == r_xe) begin
              r_cx <= r_xs;
              if (r_cy == r_ye) begin
                r_cy         <= r_ys;
                r_frame_done <= 1'b1;
              end else begin
                r_cy <= r_cy + 8'd1;
              end
            end else begin
              r_cx <= r_cx + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign cmd_valid  = r_cmd_valid;
  assign cmd_code   = r_cmd_code;
  assign pix_valid  = r_pix_valid;
  assign pix_data   = r_pix_data;
  assign pix_x      = r_pix_x;
  assign pix_y      = r_pix_y;
  assign frame_done = r_frame_done;
  assign sleep_out  = r_sleep;
  assign disp_on    = r_disp;
  assign invert_on  = r_inv;
  assign madctl     = r_madctl;
  assign colmod     = r_colmod;
  assign byte_valid = w_byte_valid;
  assign byte_data  = w_byte_data;
  assign byte_dc    = w_byte_dc;

`ifdef LCD_RX_STATS_EN
  logic [15:0] r_err_count;
  logic [31:0] r_pix_count;
  logic        w_err_cmd;
  logic [15:0] w_err_inc;

  // a partial-byte drop and a decoder error can land in the same cycle
  assign w_err_cmd = w_cmd && ((r_state == ST_RAM_LO) ||
                     ((r_state == ST_PARAM) && is_window_cmd(r_cmd) && (r_pidx < 3'd4)));
  assign w_err_inc = {15'd0, w_err_cmd} + {15'd0, w_partial_drop};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err_count <= 16'd0;
      r_pix_count <= 32'd0;
    end else begin
      if (r_err_count > (16'hFFFF - w_err_inc)) r_err_count <= 16'hFFFF;
      else                                      r_err_count <= r_err_count + w_err_inc;
      if (r_pix_valid && (r_pix_count != 32'hFFFF_FFFF)) r_pix_count <= r_pix_count + 32'd1;
    end
  end

  assign err_count = r_err_count;
  assign pix_count = r_pix_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lcd_spi_rx.sv
//==============================================================================
// Module : tb_lcd_spi_rx
// Brief  : Self-checking bench for lcd_spi_rx against a queue-based LCD model.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_lcd_spi_rx;

  localparam int SYNC = 2;
  localparam int COLS = 128;
  localparam int ROWS = 160;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_dc = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_dc;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic [7:0]  pix_x;
  logic [7:0]  pix_y;
  logic        frame_done;
  logic        sleep_out;
  logic        disp_on;
  logic        invert_on;
  logic [7:0]  madctl;
  logic [7:0]  colmod;
`ifdef LCD_RX_STATS_EN
  logic [15:0] err_count;
  logic [31:0] pix_count;
`endif

  lcd_spi_rx #(
    .SYNC_STAGES (SYNC),
    .COLS        (COLS),
    .ROWS        (ROWS)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_dc     (spi_dc),
    .spi_mosi   (spi_mosi),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_done (frame_done),
    .sleep_out  (sleep_out),
    .disp_on    (disp_on),
    .invert_on  (invert_on),
    .madctl     (madctl),
    .colmod     (colmod)
`ifdef LCD_RX_STATS_EN
    ,
    .err_count  (err_count),
    .pix_count  (pix_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  int g_half = 2;
  int unsigned last_rise_cyc = 0;
  int unsigned bv_cyc = 0;

  // observed transactions: {dc,data}, opcode, {frame_done,data,x,y}
  bit [8:0]  got_b[$];
  bit [7:0]  got_c[$];
  bit [32:0] got_p[$];
  bit [8:0]  exp_b[$];
  bit [7:0]  exp_c[$];
  bit [32:0] exp_p[$];

  always @(negedge clk) begin
    if (resetn) begin
      if (byte_valid) begin
        got_b.push_back({byte_dc, byte_data});
        bv_cyc = cyc;
      end
      if (cmd_valid) got_c.push_back(cmd_code);
      if (pix_valid) got_p.push_back({frame_done, pix_data, pix_x, pix_y});
    end
  end

  // behavioural LCD model
  localparam int M_IDLE = 0, M_PARAM = 1, M_HI = 2, M_LO = 3;
  int       m_mode;
  bit [7:0] m_cmd, m_xs, m_xe, m_ys, m_ye, m_cx, m_cy, m_hi, m_madctl, m_colmod;
  bit       m_sleep, m_disp, m_inv;
  bit [7:0] m_par[$];
  int       m_err, m_pix;

  function automatic void model_regs_reset();
    m_mode = M_IDLE; m_cmd = 8'h00;
    m_xs = 8'd0; m_xe = 8'(COLS - 1); m_ys = 8'd0; m_ye = 8'(ROWS - 1);
    m_cx = 8'd0; m_cy = 8'd0; m_hi = 8'd0;
    m_madctl = 8'd0; m_colmod = 8'd0;
    m_sleep = 1'b0; m_disp = 1'b0; m_inv = 1'b0;
    m_par.delete();
  endfunction

  function automatic void model_byte(bit dc, bit [7:0] d);
    bit fd;
    exp_b.push_back({dc, d});
    if (!dc) begin
      exp_c.push_back(d);
      if (m_mode == M_LO) m_err++;
      if (m_mode == M_PARAM && (m_cmd == 8'h2A || m_cmd == 8'h2B) && m_par.size() < 4) m_err++;
      m_cmd = d;
      m_par.delete();
      m_mode = M_IDLE;
      case (d)
        8'h01: model_regs_reset();
        8'h10: m_sleep = 1'b0;
        8'h11: m_sleep = 1'b1;
        8'h20: m_inv = 1'b0;
        8'h21: m_inv = 1'b1;
        8'h28: m_disp = 1'b0;
        8'h29: m_disp = 1'b1;
        8'h2C: begin m_cx = m_xs; m_cy = m_ys; m_mode = M_HI; end
        default: m_mode = M_PARAM;
      endcase
    end else begin
      case (m_mode)
        M_PARAM: begin
          m_par.push_back(d);
          if (m_par.size() == 4 && m_cmd == 8'h2A) begin m_xs = m_par[1]; m_xe = m_par[3]; end
          if (m_par.size() == 4 && m_cmd == 8'h2B) begin m_ys = m_par[1]; m_ye = m_par[3]; end
          if (m_par.size() == 1 && m_cmd == 8'h36) m_madctl = d;
          if (m_par.size() == 1 && m_cmd == 8'h3A) m_colmod = d;
        end
        M_HI: begin m_hi = d; m_mode = M_LO; end
        M_LO: begin
          fd = (m_cx == m_xe) && (m_cy == m_ye);
          exp_p.push_back({fd, m_hi, d, m_cx, m_cy});
          m_pix++;
          if (m_cx == m_xe) begin
            m_cx = m_xs;
            m_cy = (m_cy == m_ye) ? m_ys : m_cy + 8'd1;
          end else begin
            m_cx = m_cx + 8'd1;
          end
          m_mode = M_HI;
        end
        default: ;
      endcase
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input bit dc, input bit [7:0] d, input int nbits);
    spi_cs_n = 1'b0;
    spi_dc   = dc;
    tick(g_half);
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = d[i];
      tick(g_half);
      spi_sclk = 1'b1;
      last_rise_cyc = cyc;
      tick(g_half);
      spi_sclk = 1'b0;
    end
    tick(g_half);
    spi_cs_n = 1'b1;
    tick(3);
  endtask

  task automatic send(input bit dc, input bit [7:0] d);
    spi_bits(dc, d, 8);
    model_byte(dc, d);
  endtask

  task automatic drain_and_clear_start();
    tick(12);
  endtask

  task automatic clear_q();
    got_b.delete(); got_c.delete(); got_p.delete();
    exp_b.delete(); exp_c.delete(); exp_p.delete();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    model_regs_reset();
    m_err = 0; m_pix = 0;
    tick(4);
    resetn = 1'b1;
    tick(3);
    n_chk++;
    if ({byte_valid, byte_data, byte_dc} !== 10'd0) begin
      n_fail++; $display("FAIL reset_byte: got %h expected 0", {byte_valid, byte_data, byte_dc});
    end
    n_chk++;
    if ({cmd_valid, cmd_code} !== 9'd0) begin
      n_fail++; $display("FAIL reset_cmd: got %h expected 0", {cmd_valid, cmd_code});
    end
    n_chk++;
    if ({pix_valid, pix_data, pix_x, pix_y, frame_done} !== 34'd0) begin
      n_fail++; $display("FAIL reset_pix: got %h expected 0", {pix_valid, pix_data, pix_x, pix_y, frame_done});
    end
    n_chk++;
    if ({sleep_out, disp_on, invert_on, madctl, colmod} !== 19'd0) begin
      n_fail++; $display("FAIL reset_status: got %h expected 0", {sleep_out, disp_on, invert_on, madctl, colmod});
    end
`ifdef LCD_RX_STATS_EN
    n_chk++;
    if ({err_count, pix_count} !== 48'd0) begin
      n_fail++; $display("FAIL reset_stats: got %h expected 0", {err_count, pix_count});
    end
`endif
  endtask

  task automatic test_commands();
    clear_q();
    g_half = 3;
    send(1'b0, 8'h11);
    send(1'b0, 8'h29);
    tick(12);
    n_chk++;
    if (bv_cyc - last_rise_cyc !== SYNC + 2) begin
      n_fail++; $display("FAIL byte_latency: got %0d expected %0d", bv_cyc - last_rise_cyc, SYNC + 2);
    end
    n_chk++;
    if (got_b.size() != 2 || got_b[0] !== {1'b0, 8'h11} || got_b[1] !== {1'b0, 8'h29}) begin
      n_fail++; $display("FAIL cmd_bytes: got %0d bytes expected 011,029", got_b.size());
    end
    n_chk++;
    if (got_c.size() != 2 || got_c[0] !== 8'h11 || got_c[1] !== 8'h29) begin
      n_fail++; $display("FAIL cmd_codes: got %0d codes expected 11,29", got_c.size());
    end
    n_chk++;
    if ({sleep_out, disp_on, invert_on} !== 3'b110) begin
      n_fail++; $display("FAIL cmd_status: got %b expected 110", {sleep_out, disp_on, invert_on});
    end
  endtask

  task automatic test_window();
    bit [7:0] seq[13] = '{8'h2A, 8'h00, 8'h1A, 8'h00, 8'h69,
                          8'h2B, 8'h00, 8'h01, 8'h00, 8'hA0,
                          8'h2C, 8'hF8, 8'h00};
    clear_q();
    g_half = 2;
    foreach (seq[i]) send(!(i == 0 || i == 5 || i == 10), seq[i]);
    send(1'b1, 8'h07);
    send(1'b1, 8'hE0);
    tick(12);
    n_chk++;
    if (got_p.size() != 2 || got_p[0] !== {1'b0, 16'hF800, 8'h1A, 8'h01}
                          || got_p[1] !== {1'b0, 16'h07E0, 8'h1B, 8'h01}) begin
      n_fail++; $display("FAIL window_pix: got %0d pixels first %h expected F800@1A,01 07E0@1B,01",
                         got_p.size(), (got_p.size() > 0) ? got_p[0] : 33'd0);
    end
    n_chk++;
    if (got_c.size() != exp_c.size()) begin
      n_fail++; $display("FAIL window_cmds: got %0d expected %0d", got_c.size(), exp_c.size());
    end
  endtask

  task automatic test_frame();
    bit [7:0] ex_x[5] = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0};
    bit [7:0] ex_y[5] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd0};
    clear_q();
    send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h00); send(1'b1, 8'h00); send(1'b1, 8'h01);
    send(1'b0, 8'h2B); send(1'b1, 8'h00); send(1'b1, 8'h00); send(1'b1, 8'h00); send(1'b1, 8'h01);
    send(1'b0, 8'h2C);
    for (int i = 0; i < 10; i++) send(1'b1, 8'($urandom));
    tick(12);
    n_chk++;
    if (got_p.size() != 5) begin
      n_fail++; $display("FAIL frame_count: got %0d expected 5", got_p.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_chk++;
        if (got_p[i][32] !== (i == 3) || got_p[i][15:8] !== ex_x[i] || got_p[i][7:0] !== ex_y[i]
            || got_p[i] !== exp_p[i]) begin
          n_fail++; $display("FAIL frame_pix%0d: got %h expected %h", i, got_p[i], exp_p[i]);
        end
      end
    end
  endtask

  task automatic test_partial();
    clear_q();
    spi_bits(1'b0, 8'($urandom), 5);
    m_err++;
    send(1'b1, 8'hA5);
    tick(12);
    n_chk++;
    if (got_b.size() != 1 || got_b[0][7:0] !== 8'hA5) begin
      n_fail++; $display("FAIL partial_byte: got %0d bytes first %h expected one A5",
                         got_b.size(), (got_b.size() > 0) ? got_b[0] : 9'd0);
    end
`ifdef LCD_RX_STATS_EN
    n_chk++;
    if (err_count !== 16'(m_err)) begin
      n_fail++; $display("FAIL partial_err: got %0d expected %0d", err_count, m_err);
    end
`endif
  endtask

  task automatic test_back_to_back();
    clear_q();
    g_half = 2;
    send(1'b0, 8'h2C);
    for (int i = 0; i < 4; i++) send(1'b1, 8'($urandom));
    send(1'b1, 8'h12);
    send(1'b0, 8'h2C);
    send(1'b1, 8'h34);
    send(1'b1, 8'h56);
    tick(12);
    n_chk++;
    if (got_p.size() != exp_p.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d expected %0d", got_p.size(), exp_p.size());
    end else begin
      foreach (exp_p[i]) begin
        n_chk++;
        if (got_p[i] !== exp_p[i]) begin
          n_fail++; $display("FAIL b2b_pix%0d: got %h expected %h", i, got_p[i], exp_p[i]);
        end
      end
    end
    n_chk++;
    if (got_p.size() != 3 || got_p[2][31:16] !== 16'h3456 || got_p[2][15:0] !== 16'h0000) begin
      n_fail++; $display("FAIL b2b_drop: got %h expected 3456 at 00,00",
                         (got_p.size() > 0) ? got_p[got_p.size()-1] : 33'd0);
    end
`ifdef LCD_RX_STATS_EN
    n_chk++;
    if ({err_count, pix_count} !== {16'(m_err), 32'(m_pix)}) begin
      n_fail++; $display("FAIL b2b_stats: got %0d/%0d expected %0d/%0d", err_count, pix_count, m_err, m_pix);
    end
`endif
  endtask

  task automatic test_random();
    bit [7:0] ops[13] = '{8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h28, 8'h29,
                          8'h2A, 8'h2B, 8'h2C, 8'h2C, 8'h36, 8'h3A};
    int r;
    clear_q();
    for (int n = 0; n < 90; n++) begin
      g_half = $urandom_range(2, 4);
      r = $urandom_range(0, 9);
      if (r < 2) send(1'b0, (r == 0) ? 8'($urandom) : ops[$urandom_range(0, 12)]);
      else       send(1'b1, (m_mode == M_PARAM && m_par.size() == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom));
    end
    tick(12);
    n_chk++;
    if (got_b.size() != exp_b.size() || got_c.size() != exp_c.size() || got_p.size() != exp_p.size()) begin
      n_fail++; $display("FAIL rand_counts: got %0d/%0d/%0d expected %0d/%0d/%0d", got_b.size(),
                         got_c.size(), got_p.size(), exp_b.size(), exp_c.size(), exp_p.size());
    end else begin
      foreach (exp_c[i]) begin
        n_chk++;
        if (got_c[i] !== exp_c[i]) begin
          n_fail++; $display("FAIL rand_cmd%0d: got %h expected %h", i, got_c[i], exp_c[i]);
        end
      end
      foreach (exp_p[i]) begin
        n_chk++;
        if (got_p[i] !== exp_p[i]) begin
          n_fail++; $display("FAIL rand_pix%0d: got %h expected %h", i, got_p[i], exp_p[i]);
        end
      end
    end
    n_chk++;
    if ({sleep_out, disp_on, invert_on, madctl, colmod} !== {m_sleep, m_disp, m_inv, m_madctl, m_colmod}) begin
      n_fail++; $display("FAIL rand_status: got %h expected %h", {sleep_out, disp_on, invert_on, madctl, colmod},
                         {m_sleep, m_disp, m_inv, m_madctl, m_colmod});
    end
`ifdef LCD_RX_STATS_EN
    n_chk++;
    if ({err_count, pix_count} !== {16'(m_err), 32'(m_pix)}) begin
      n_fail++; $display("FAIL rand_stats: got %0d/%0d expected %0d/%0d", err_count, pix_count, m_err, m_pix);
    end
`endif
  endtask

  task automatic test_reset_mid();
    g_half = 2;
    send(1'b0, 8'h11);
    send(1'b0, 8'h2C);
    send(1'b1, 8'hC3);
    spi_cs_n = 1'b0;
    spi_dc   = 1'b1;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      spi_mosi = 1'b1; tick(2); spi_sclk = 1'b1; tick(2); spi_sclk = 1'b0;
    end
    resetn = 1'b0;
    tick(3);
    spi_cs_n = 1'b1;
    resetn   = 1'b1;
    model_regs_reset();
    m_err = 0; m_pix = 0;
    tick(4);
    clear_q();
    send(1'b1, 8'h55);
    send(1'b1, 8'hAA);
    tick(12);
    n_chk++;
    if (got_p.size() != 0 || exp_p.size() != 0) begin
      n_fail++; $display("FAIL rstmid_pix: got %0d pixels expected 0", got_p.size());
    end
    n_chk++;
    if ({cmd_code, pix_data, pix_x, pix_y, sleep_out, disp_on, invert_on, madctl, colmod} !== 59'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %h expected 0",
                         {cmd_code, pix_data, pix_x, pix_y, sleep_out, disp_on, invert_on, madctl, colmod});
    end
    n_chk++;
    if (got_b.size() != 2 || got_b[0] !== {1'b1, 8'h55} || got_b[1] !== {1'b1, 8'hAA}) begin
      n_fail++; $display("FAIL rstmid_bytes: got %0d bytes expected 155,1AA", got_b.size());
    end
`ifdef LCD_RX_STATS_EN
    n_chk++;
    if ({err_count, pix_count} !== 48'd0) begin
      n_fail++; $display("FAIL rstmid_stats: got %0d/%0d expected 0/0", err_count, pix_count);
    end
`endif
  endtask

  initial begin
    #700000;
    $display("FAIL timeout: got no end of test expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_commands();
    test_window();
    test_frame();
    test_partial();
    test_back_to_back();
    test_random();
    test_reset_mid();
    drain_and_clear_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
